// File: rtl/mem_pkg.sv
// Shared definitions for the MEM_* bus responder: access sizes, FSM state type
// and the byte-lane write-mask helper.
package mem_pkg;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } respState_t;

    // Expects a size already normalised to BYTE/HALF/WORD and an aligned offset.
    function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            MEM_SIZE_BYTE: laneMask = 4'b0001 << offset;
            MEM_SIZE_HALF: laneMask = offset[1] ? 4'b1100 : 4'b0011;
            default:       laneMask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_ram_array.sv
// Single-port word RAM with per-byte write enables and synchronous read.
module mem_ram_array #(
    parameter int    ADDR_WIDTH = 12,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rdEn,
    input  logic [3:0]            byteWe,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wrData,
    output logic [31:0]           rdData
);

    logic [31:0] mem [2**ADDR_WIDTH];

    // NOTE: the array has no reset so it maps onto block RAM; contents survive Reset.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (byteWe[lane]) mem[addr][8*lane +: 8] <= wrData[8*lane +: 8];
        end
        if (rdEn) rdData <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// MEM_* bus target: single-beat reads/writes with WAIT_STATES wait cycles.
// Define MEM_RESP_FAULT_EN to add misalignment/range checking and the MEM_Fault port.
module mem_responder
    import mem_pkg::*;
#(
    parameter int    ADDR_WIDTH  = 12,
    parameter int    WAIT_STATES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_Cmd,
    input  logic        MEM_We,
    input  logic [1:0]  MEM_ByteEnable,
    input  logic [31:0] MEM_Addr,
    input  logic [31:0] MEM_DataIn,
    output logic [31:0] MEM_DataOut,
    output logic        MEM_Ready,
    output logic        MEM_DataReady
`ifdef MEM_RESP_FAULT_EN
    ,output logic       MEM_Fault
`endif
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    respState_t  state;
    logic [3:0]  waitCnt;
    logic        rspWrite;
    logic [1:0]  rspSize;
    logic [1:0]  rspOffset;
    logic        rspFault;
    logic        faultPulse;
    logic [31:0] dataHold;

    logic [1:0]  cmdSize;
    logic [1:0]  cmdOffset;
    logic [31:0] wrData;
    logic        cmdFault;
    logic [3:0]  byteWe;
    logic        rdEn;
    logic [31:0] ramQ;
    logic [31:0] shifted;
    logic [31:0] respData;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        cmdSize   = MEM_ByteEnable[1] ? MEM_SIZE_WORD : MEM_ByteEnable;
        cmdOffset = 2'b00;
        wrData    = MEM_DataIn;
        case (cmdSize)
            MEM_SIZE_BYTE: begin
                cmdOffset = MEM_Addr[1:0];
                wrData    = {4{MEM_DataIn[7:0]}};
            end
            MEM_SIZE_HALF: begin
                cmdOffset = {MEM_Addr[1], 1'b0};
                wrData    = {2{MEM_DataIn[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MEM_RESP_FAULT_EN
    assign cmdFault = (|MEM_Addr[31:ADDR_WIDTH+2])
                   || (cmdSize == MEM_SIZE_HALF && MEM_Addr[0])
                   || (cmdSize == MEM_SIZE_WORD && MEM_Addr[1:0] != 2'b00);
    assign MEM_Fault = faultPulse;
`else
    assign cmdFault = 1'b0;
    logic unusedBits;
    assign unusedBits = ^{MEM_Addr[31:ADDR_WIDTH+2], faultPulse};
`endif

    assign byteWe = (MEM_Ready && MEM_Cmd && MEM_We && !cmdFault)
                  ? laneMask(cmdSize, cmdOffset) : 4'b0000;
    assign rdEn   = MEM_Ready && MEM_Cmd && !MEM_We;

    mem_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) uRam (
        .clk    (Clk),
        .rdEn   (rdEn),
        .byteWe (byteWe),
        .addr   (MEM_Addr[ADDR_WIDTH+1:2]),
        .wrData (wrData),
        .rdData (ramQ)
    );

    // Right-justify the addressed lanes; upper bits are zero-filled.
    assign shifted = ramQ >> {rspOffset, 3'b000};

    always_comb begin
        case (rspSize)
            MEM_SIZE_BYTE: respData = {24'b0, shifted[7:0]};
            MEM_SIZE_HALF: respData = {16'b0, shifted[15:0]};
            default:       respData = shifted;
        endcase
        if (rspFault) respData = '0;
    end

    assign MEM_DataOut = MEM_DataReady ? respData : dataHold;

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values, e.g. dataHold captures the response being replaced.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            waitCnt       <= '0;
            rspWrite      <= 1'b0;
            rspSize       <= MEM_SIZE_BYTE;
            rspOffset     <= 2'b00;
            rspFault      <= 1'b0;
            faultPulse    <= 1'b0;
            dataHold      <= '0;
            MEM_Ready     <= 1'b1;
            MEM_DataReady <= 1'b0;
        end else begin
            MEM_DataReady <= 1'b0;
            faultPulse    <= 1'b0;
            if (MEM_DataReady) dataHold <= respData;
            unique case (state)
                IDLE, RESP: begin
                    if (MEM_Cmd) begin
                        rspWrite  <= MEM_We;
                        rspSize   <= cmdSize;
                        rspOffset <= cmdOffset;
                        rspFault  <= cmdFault;
                        if (WAIT_STATES > 0) begin
                            state     <= WAIT;
                            waitCnt   <= WAIT_LOAD;
                            MEM_Ready <= 1'b0;
                        end else begin
                            state         <= RESP;
                            MEM_DataReady <= !MEM_We;
                            faultPulse    <= cmdFault;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (waitCnt == 4'd1) begin
                        state         <= RESP;
                        MEM_Ready     <= 1'b1;
                        MEM_DataReady <= !rspWrite;
                        faultPulse    <= rspFault;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_STATES 0 and 2) checked against a
// byte-addressed reference memory; honours MEM_RESP_FAULT_EN if defined.
module tb_mem_responder;

    localparam int AW    = 12;
    localparam int BYTES = 1 << (AW + 2);

    logic        clk = 1'b0;
    logic        rstN;
    logic        cmd  [2];
    logic        we   [2];
    logic [1:0]  be   [2];
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        rdy  [2];
    logic        drdy [2];
`ifdef MEM_RESP_FAULT_EN
    logic        flt  [2];
`endif

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .Clk(clk), .Reset(rstN), .MEM_Cmd(cmd[0]), .MEM_We(we[0]), .MEM_ByteEnable(be[0]),
        .MEM_Addr(addr[0]), .MEM_DataIn(din[0]), .MEM_DataOut(dout[0]),
        .MEM_Ready(rdy[0]), .MEM_DataReady(drdy[0])
`ifdef MEM_RESP_FAULT_EN
        , .MEM_Fault(flt[0])
`endif
    );

    mem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut2 (
        .Clk(clk), .Reset(rstN), .MEM_Cmd(cmd[1]), .MEM_We(we[1]), .MEM_ByteEnable(be[1]),
        .MEM_Addr(addr[1]), .MEM_DataIn(din[1]), .MEM_DataOut(dout[1]),
        .MEM_Ready(rdy[1]), .MEM_DataReady(drdy[1])
`ifdef MEM_RESP_FAULT_EN
        , .MEM_Fault(flt[1])
`endif
    );

    int nCompared = 0;
    int nMismatch = 0;

    logic [7:0]  refMem   [2][BYTES];
    logic [31:0] lastRead [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nBytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit isFault(input logic [31:0] a, input logic [1:0] sz);
`ifdef MEM_RESP_FAULT_EN
        if ((a >> (AW + 2)) != 0) return 1'b1;
        return (a % nBytes(sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Byte address inside the array, aliased and aligned down to the access size.
    function automatic int effAddr(input logic [31:0] a, input logic [1:0] sz);
        int ea = int'(a & (BYTES - 1));
        return ea - (ea % nBytes(sz));
    endfunction

    function automatic logic [31:0] modelRead(input int sel, input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] v = '0;
        int ea = effAddr(a, sz);
        if (isFault(a, sz)) return '0;
        for (int i = 0; i < nBytes(sz); i++) v[8*i +: 8] = refMem[sel][ea + i];
        return v;
    endfunction

    task automatic modelWrite(input int sel, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int ea = effAddr(a, sz);
        if (isFault(a, sz)) return;
        for (int i = 0; i < nBytes(sz); i++) refMem[sel][ea + i] = d[8*i +: 8];
    endtask

    // Called at a negedge with the DUT ready; returns at the negedge of the response cycle.
    task automatic txn(input int sel, input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd);
        int          ws       = (sel == 0) ? 0 : 2;
        bit          expFault = isFault(a, sz);
        logic [31:0] expData  = modelRead(sel, a, sz);
        check("ready_before_cmd", 32'(rdy[sel]), 32'd1);
        cmd[sel] = 1'b1; we[sel] = w; be[sel] = sz; addr[sel] = a; din[sel] = d;
        @(negedge clk);
        cmd[sel] = 1'b0; addr[sel] = $urandom; din[sel] = $urandom;
        if (w) modelWrite(sel, a, sz, d);
        for (int c = 1; c <= ws; c++) begin
            check("ready_low_in_wait", 32'(rdy[sel]), 32'd0);
            check("no_dataready_in_wait", 32'(drdy[sel]), 32'd0);
            if (c == 1 && ws >= 2) begin
                // A command while not ready must be ignored entirely.
                cmd[sel] = 1'b1; we[sel] = 1'b1; be[sel] = 2'b10;
                addr[sel] = a & ~32'h3; din[sel] = ~d;
            end else begin
                cmd[sel] = 1'b0;
            end
            @(negedge clk);
        end
        cmd[sel] = 1'b0;
        check("ready_in_resp", 32'(rdy[sel]), 32'd1);
        check("dataready_pulse", 32'(drdy[sel]), 32'(!w));
        if (!w) begin
            check("read_data", dout[sel], expData);
            lastRead[sel] = expData;
        end
`ifdef MEM_RESP_FAULT_EN
        check("fault_pulse", 32'(flt[sel]), 32'(expFault));
`endif
        rd = dout[sel];
    endtask

    task automatic idleCheck(input int sel);
        @(negedge clk);
        check("idle_no_dataready", 32'(drdy[sel]), 32'd0);
        check("dataout_holds", dout[sel], lastRead[sel]);
    endtask

    typedef struct {
        bit          w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd, e10, e14, ra;

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < BYTES; i++) refMem[s][i] = 8'h00;
            cmd[s] = 1'b0; we[s] = 1'b0; be[s] = 2'b00; addr[s] = '0; din[s] = '0;
            lastRead[s] = '0;
        end

        vecs.push_back('{1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b0, 2'b10, 32'h10, 32'h0,        32'hDEADBEEF});
        vecs.push_back('{1'b1, 2'b00, 32'h13, 32'hFFFFFFAA, 32'h0});
        vecs.push_back('{1'b0, 2'b10, 32'h10, 32'h0,        32'hAAADBEEF});
        vecs.push_back('{1'b0, 2'b01, 32'h12, 32'h0,        32'h0000AAAD});
        vecs.push_back('{1'b0, 2'b00, 32'h11, 32'h0,        32'h000000BE});
        vecs.push_back('{1'b1, 2'b10, 32'h14, 32'h01234567, 32'h0});
        vecs.push_back('{1'b1, 2'b01, 32'h16, 32'hFFFF5A5A, 32'h0});
        vecs.push_back('{1'b0, 2'b10, 32'h14, 32'h0,        32'h5A5A4567});
        vecs.push_back('{1'b0, 2'b01, 32'h14, 32'h0,        32'h00004567});
        vecs.push_back('{1'b0, 2'b00, 32'h17, 32'h0,        32'h0000005A});
        vecs.push_back('{1'b0, 2'b11, 32'h14, 32'h0,        32'h5A5A4567});
`ifdef MEM_RESP_FAULT_EN
        vecs.push_back('{1'b1, 2'b01, 32'h11, 32'h0000FFFF, 32'h0});
        vecs.push_back('{1'b0, 2'b10, 32'h10, 32'h0,        32'hAAADBEEF});
        vecs.push_back('{1'b0, 2'b10, 32'h1 << (AW + 2), 32'h0, 32'h0});
`else
        vecs.push_back('{1'b0, 2'b10, 32'h17, 32'h0,        32'h5A5A4567});
        vecs.push_back('{1'b0, 2'b01, 32'h13, 32'h0,        32'h0000AAAD});
        vecs.push_back('{1'b0, 2'b10, 32'h4010, 32'h0,      32'hAAADBEEF});
        vecs.push_back('{1'b1, 2'b00, 32'h80000010, 32'h11, 32'h0});
        vecs.push_back('{1'b0, 2'b10, 32'h10, 32'h0,        32'hAAADBE11});
`endif

        rstN = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset_ready", 32'(rdy[s]), 32'd1);
            check("reset_dataready", 32'(drdy[s]), 32'd0);
            check("reset_dataout", dout[s], 32'h0);
        end
        rstN = 1'b1;
        @(negedge clk);

        // Known contents for the low window used by the random phase.
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 16; w++) txn(s, 1'b1, 2'b10, 32'(w * 4), 32'h0, rd);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < vecs.size(); i++) begin
                txn(s, vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].d, rd);
                if (!vecs[i].w) check($sformatf("vector_%0d_dut%0d", i, s), rd, vecs[i].exp);
            end
            idleCheck(s);
        end

        // Back-to-back reads with no wait states.
        e10 = modelRead(0, 32'h10, 2'b10);
        e14 = modelRead(0, 32'h14, 2'b10);
        cmd[0] = 1'b1; we[0] = 1'b0; be[0] = 2'b10; addr[0] = 32'h10;
        @(negedge clk);
        check("b2b_first_ready", 32'(drdy[0]), 32'd1);
        check("b2b_first_data", dout[0], e10);
        check("b2b_ready_high", 32'(rdy[0]), 32'd1);
        addr[0] = 32'h14;
        @(negedge clk);
        check("b2b_second_ready", 32'(drdy[0]), 32'd1);
        check("b2b_second_data", dout[0], e14);
        cmd[0] = 1'b0;
        lastRead[0] = e14;
        idleCheck(0);

        // Reset during the wait phase of a read drops the response.
        cmd[1] = 1'b1; we[1] = 1'b0; be[1] = 2'b10; addr[1] = 32'h10;
        @(negedge clk);
        cmd[1] = 1'b0;
        check("pre_reset_in_wait", 32'(rdy[1]), 32'd0);
        rstN = 1'b0;
        #1;
        check("reset_mid_ready", 32'(rdy[1]), 32'd1);
        check("reset_mid_dataready", 32'(drdy[1]), 32'd0);
        check("reset_mid_dataout", dout[1], 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        lastRead[0] = '0;
        lastRead[1] = '0;
        repeat (6) begin
            @(negedge clk);
            check("dropped_read_silent", 32'(drdy[1]), 32'd0);
        end
        txn(1, 1'b0, 2'b10, 32'h10, 32'h0, rd);
        txn(1, 1'b0, 2'b10, 32'h14, 32'h0, rd);

        // Randomised traffic against the reference memory.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 300; n++) begin
                ra = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 7) == 0) ra = ra | (32'h1 << $urandom_range(AW + 2, 31));
                txn(s, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom, rd);
                if ($urandom_range(0, 3) == 0) idleCheck(s);
            end
            for (int w = 0; w < 16; w++) txn(s, 1'b0, 2'b10, 32'(w * 4), 32'h0, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
